// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor with the carry chain split into STAGES registered slices
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             ovf_q, ovf_d;
  assign b_eff = sub ? ~b : b;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic                  v_i, c_i, c_q, c_d, v_q;
    logic [SW-1:0]         as_i, bs_i, ss;
    logic [(k+1)*SW-1:0]   s_q, s_d;
    if (k == 0) begin : g_head
      assign as_i = a[SW-1:0];
      assign bs_i = b_eff[SW-1:0];
      assign c_i  = sub;
      assign v_i  = in_valid;
      assign s_d  = ss;
    end else begin : g_tail
      assign as_i = g_st[k-1].g_ops.ah_q[k*SW +: SW];
      assign bs_i = g_st[k-1].g_ops.bh_q[k*SW +: SW];
      assign c_i  = g_st[k-1].c_q;
      assign v_i  = g_st[k-1].v_q;
      assign s_d  = {ss, g_st[k-1].s_q};
    end
    // slice adder fed by the previous slice's registered carry
    always_comb {c_d, ss} = {1'b0, as_i} + {1'b0, bs_i} + {{SW{1'b0}}, c_i};
    // stage register: valid, carry and completed low sum bits advance together
    always_ff @(posedge clk)
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= c_d;
        s_q <= s_d;
      end
    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:(k+1)*SW] ah_q, bh_q, ah_d, bh_d;
      if (k == 0) begin : g_src
        assign ah_d = a[WIDTH-1:SW];
        assign bh_d = b_eff[WIDTH-1:SW];
      end else begin : g_fwd
        assign ah_d = g_st[k-1].g_ops.ah_q[WIDTH-1:(k+1)*SW];
        assign bh_d = g_st[k-1].g_ops.bh_q[WIDTH-1:(k+1)*SW];
      end
      // skew register: operand bits not yet consumed travel with the beat
      always_ff @(posedge clk)
        if (rst) begin
          ah_q <= '0;
          bh_q <= '0;
        end else if (adv) begin
          ah_q <= ah_d;
          bh_q <= bh_d;
        end
    end
  end
  // signed overflow from the top slice's operand and result sign bits
  always_comb ovf_d = (g_st[STAGES-1].as_i[SW-1] == g_st[STAGES-1].bs_i[SW-1]) &&
                      (g_st[STAGES-1].ss[SW-1] != g_st[STAGES-1].as_i[SW-1]);
  // overflow flag registered alongside the final stage
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = ovf_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for three parameterisations of pipelined_addsub
module tb_pipelined_addsub;
  typedef struct { logic [17:0] e; int c; } ent_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        iv[3], subv[3], ordy[3], ir[3], ov[3], co[3], of[3];
  logic [15:0] av[3], bv[3], sm[3];
  logic [7:0]  s0;
  logic [15:0] s1;
  logic [3:0]  s2;
  ent_t        q[$];
  int          nvec = 0, nmis = 0, ncyc = 0;
  bit          lat_chk = 1;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0][7:0]), .b(bv[0][7:0]),
    .sub(subv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]));
  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .sub(subv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]));
  pipelined_addsub #(.WIDTH(4), .STAGES(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2][3:0]), .b(bv[2][3:0]),
    .sub(subv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]));
  assign sm[0] = {8'h0, s0};
  assign sm[1] = s1;
  assign sm[2] = {12'h0, s2};

  function automatic int wof(input int d);
    return d == 0 ? 8 : d == 1 ? 16 : 4;
  endfunction
  function automatic int sof(input int d);
    return d == 0 ? 2 : d == 1 ? 4 : 1;
  endfunction

  function automatic logic [17:0] model(input int w, input int aa, input int bb, input logic s);
    longint m, x, y, r, rm;
    logic c, sa, sb, ss, o;
    m  = (64'd1 << w) - 1;
    x  = aa & m;
    y  = bb & m;
    r  = s ? x - y : x + y;
    rm = r & m;
    c  = s ? (x >= y) : (((r >> w) & 1) != 0);
    sa = ((x >> (w - 1)) & 1) != 0;
    sb = ((y >> (w - 1)) & 1) != 0;
    ss = ((rm >> (w - 1)) & 1) != 0;
    o  = s ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    return {o, c, 16'(rm)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int d, input logic v, input int aa, input int bb, input logic s, input logic r);
    ent_t e;
    iv[d] = v; av[d] = 16'(aa); bv[d] = 16'(bb); subv[d] = s; ordy[d] = r;
    #1;
    if (rst) q.delete();
    else begin
      if (ov[d] && r) begin
        chk("spurious_out", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk($sformatf("dut%0d_result", d), 64'({of[d], co[d], sm[d]}), 64'(e.e));
          if (lat_chk) chk($sformatf("dut%0d_latency", d), 64'(ncyc - e.c), 64'(sof(d)));
        end
      end
      if (v && ir[d]) begin
        e.e = model(wof(d), aa, bb, s);
        e.c = ncyc;
        q.push_back(e);
      end
    end
    ncyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 0; av[d] = 0; bv[d] = 0; subv[d] = 0; ordy[d] = 1;
    end
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_out_valid", 64'(ov[0]), 0);
    chk("rst_sum", 64'(sm[0]), 0);
    chk("rst_cout_ovf", 64'({co[0], of[0]}), 0);
    chk("rst_in_ready", 64'(ir[0]), 1);
    cyc(0, 1, 200, 100, 0, 1);
    cyc(0, 1, 127, 1, 0, 1);
    cyc(0, 1, 128, 1, 1, 1);
    cyc(0, 1, 5, 7, 1, 1);
    cyc(0, 1, 7, 5, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("dut0_drain", 64'(q.size()), 0);
    lat_chk = 0;
    cyc(0, 1, 1, 1, 0, 1);
    cyc(0, 1, 2, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 3, 3, 0, 0);
      chk("stall_in_ready", 64'(ir[0]), 0);
      chk("stall_sum_hold", 64'(sm[0]), 2);
    end
    cyc(0, 1, 3, 3, 0, 1);
    cyc(0, 1, 4, 4, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    chk("bp_drain", 64'(q.size()), 0);
    lat_chk = 1;
    cyc(0, 1, 10, 1, 0, 1);
    cyc(0, 1, 20, 2, 0, 1);
    rst = 1;
    cyc(0, 1, 9, 9, 0, 1);
    rst = 0;
    chk("midrst_out_valid", 64'(ov[0]), 0);
    chk("midrst_sum", 64'(sm[0]), 0);
    chk("midrst_in_ready", 64'(ir[0]), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("midrst_no_stale", 64'(ov[0]), 0);
    end
    cyc(1, 1, 16'hFFFF, 1, 0, 1);
    cyc(1, 1, 16'h8000, 1, 1, 1);
    cyc(1, 1, 0, 0, 1, 1);
    cyc(1, 1, 16'h7FFF, 16'h7FFF, 0, 1);
    for (int i = 0; i < 1000; ) begin
      logic v;
      v = $urandom_range(3) != 0;
      cyc(1, v, int'($urandom_range(65535)), int'($urandom_range(65535)), 1'($urandom_range(1)), 1);
      if (v) i++;
    end
    repeat (6) cyc(1, 0, 0, 0, 0, 1);
    chk("dut1_drain", 64'(q.size()), 0);
    cyc(2, 1, 7, 7, 0, 1);
    cyc(2, 1, 3, 5, 1, 1);
    repeat (3) cyc(2, 0, 0, 0, 0, 1);
    chk("dut2_drain", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
